// File: rtl/bram_sd_pkg.sv
// Shared types and helpers for the backup-RAM save/load controller.
// Default geometry: 16 sectors of 256 words.
package bram_sd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        FMT
    } state_e;

    localparam int SECTORS_DEF      = 16;
    localparam int SECTOR_WORDS_DEF = 256;
    localparam int ADDR_W = $clog2(SECTORS_DEF * SECTOR_WORDS_DEF);
    localparam int SEC_W  = $clog2(SECTORS_DEF);

    // rising=1 detects 0->1, rising=0 detects 1->0
    function automatic logic edge_det(input logic cur,
                                      input logic old,
                                      input logic rising);
        return rising ? (cur & ~old) : (~cur & old);
    endfunction

endpackage

// File: rtl/bram_fmt_seq.sv
// Format sequencer: walks the RAM one word per cycle emitting the
// default header words, then zeros when full clearing is enabled.
module bram_fmt_seq
    import bram_sd_pkg::*;
#(
    parameter int AW           = 12,
    parameter int DATA_W       = 16,
    parameter int DEF_WORDS    = 4,
    parameter logic [DEF_WORDS*DATA_W-1:0] DEF_INIT =
        {16'h8010, 16'h8800, 16'h4D42, 16'h5548},
    parameter bit FORMAT_CLEAR = 1'b0
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              start_i,
    output logic              run_o,
    output logic              done_o,
    output logic [AW-1:0]     addr_o,
    output logic [DATA_W-1:0] data_o
);

    localparam logic [AW-1:0] LAST =
        FORMAT_CLEAR ? {AW{1'b1}} : AW'(DEF_WORDS - 1);

    logic          run_q, run_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            run_q <= run_d;
            cnt_q <= cnt_d;
        end
    end

    assign done_o = run_q & (cnt_q == LAST);
    assign run_o  = run_q;
    assign addr_o = cnt_q;

    always_comb begin
        run_d = run_q;
        cnt_d = cnt_q;
        if (start_i) begin
            run_d = 1'b1;
            cnt_d = '0;
        end else if (run_q) begin
            cnt_d = cnt_q + AW'(1);
            if (done_o) run_d = 1'b0;
        end
    end

    // header words first, zero beyond them
    always_comb begin
        data_o = '0;
        for (int i = 0; i < DEF_WORDS; i++) begin
            if (cnt_q == AW'(i)) data_o = DEF_INIT[i*DATA_W +: DATA_W];
        end
    end

endmodule

// File: rtl/bram_sd_ctrl.sv
// Backup-RAM save/load controller: sequences multi-sector transfers
// between backup RAM port B and the mounted save image via sd_*.
module bram_sd_ctrl
    import bram_sd_pkg::*;
#(
    parameter int SECTORS      = SECTORS_DEF,
    parameter int SECTOR_WORDS = SECTOR_WORDS_DEF,
    parameter int DATA_W       = 16,
    parameter int LBA_W        = 32,
    parameter logic [LBA_W-1:0] LBA_BASE = '0,
    parameter int DEF_WORDS    = 4,
    parameter logic [DEF_WORDS*DATA_W-1:0] DEF_INIT =
        {16'h8010, 16'h8800, 16'h4D42, 16'h5548},
    parameter bit FORMAT_CLEAR = 1'b0
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic downloading,
    input  logic img_mounted,
    input  logic img_readonly,
    input  logic img_size_nz,
    input  logic load_req,
    input  logic save_req,
    input  logic format_req,
    input  logic autosave_en,
    input  logic osd_open,
    input  logic core_we,
    output logic [LBA_W-1:0] sd_lba,
    output logic sd_rd,
    output logic sd_wr,
    input  logic sd_ack,
    input  logic [$clog2(SECTOR_WORDS)-1:0] sd_buff_addr,
    input  logic sd_buff_wr,
    output logic [$clog2(SECTORS*SECTOR_WORDS)-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic ram_we,
    output logic ram_sel_fmt,
    output logic bk_ena,
    output logic bk_busy,
    output logic bk_loading,
    output logic bk_pending
);

    localparam int AW = $clog2(SECTORS * SECTOR_WORDS);
    localparam int SW = $clog2(SECTORS);
    localparam logic [SW-1:0] SEC_LAST = SW'(SECTORS - 1);

    state_e           state_q, state_d;
    logic [SW-1:0]    sec_q, sec_d;
    logic [LBA_W-1:0] lba_q, lba_d;
    logic rd_q, rd_d, wr_q, wr_d, ld_q, ld_d;
    logic ena_q, ena_d, pend_q, pend_d;
    logic old_load_q, old_save_q, old_fmt_q, old_dl_q, old_ack_q;

    logic save_trig, load_go, save_go, fmt_go;
    logic start_xfer, fmt_start, fmt_set;
    logic fmt_run, fmt_done;
    logic [AW-1:0]     fmt_addr;
    logic [DATA_W-1:0] fmt_data;

    bram_fmt_seq #(
        .AW           (AW),
        .DATA_W       (DATA_W),
        .DEF_WORDS    (DEF_WORDS),
        .DEF_INIT     (DEF_INIT),
        .FORMAT_CLEAR (FORMAT_CLEAR)
    ) u_fmt (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .start_i (fmt_start),
        .run_o   (fmt_run),
        .done_o  (fmt_done),
        .addr_o  (fmt_addr),
        .data_o  (fmt_data)
    );

    assign save_trig = save_req | (pend_q & osd_open & autosave_en);
    assign load_go = edge_det(load_req, old_load_q, 1'b1)
                   | (edge_det(downloading, old_dl_q, 1'b0) & img_size_nz);
    assign save_go = edge_det(save_trig, old_save_q, 1'b1);
    assign fmt_go  = edge_det(format_req, old_fmt_q, 1'b1);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            sec_q      <= '0;
            lba_q      <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            ld_q       <= 1'b0;
            ena_q      <= 1'b0;
            pend_q     <= 1'b0;
            old_load_q <= 1'b0;
            old_save_q <= 1'b0;
            old_fmt_q  <= 1'b0;
            old_dl_q   <= 1'b0;
            old_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sec_q      <= sec_d;
            lba_q      <= lba_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            ld_q       <= ld_d;
            ena_q      <= ena_d;
            pend_q     <= pend_d;
            old_load_q <= load_req;
            old_save_q <= save_trig;
            old_fmt_q  <= format_req;
            old_dl_q   <= downloading;
            old_ack_q  <= sd_ack;
        end
    end

    always_comb begin
        state_d    = state_q;
        sec_d      = sec_q;
        lba_d      = lba_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        ld_d       = ld_q;
        start_xfer = 1'b0;
        fmt_start  = 1'b0;
        fmt_set    = 1'b0;
        unique case (state_q)
            IDLE: begin
                // load wins over save when both fire together
                if (ena_q && (load_go || save_go)) begin
                    state_d    = REQ;
                    sec_d      = '0;
                    lba_d      = LBA_BASE;
                    rd_d       = load_go;
                    wr_d       = ~load_go;
                    ld_d       = load_go;
                    start_xfer = 1'b1;
                end else if (fmt_go) begin
                    state_d   = FMT;
                    fmt_start = 1'b1;
                    fmt_set   = ena_q;
                end
            end
            REQ: begin
                if (edge_det(sd_ack, old_ack_q, 1'b1)) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (edge_det(sd_ack, old_ack_q, 1'b0)) begin
                    if (sec_q == SEC_LAST) begin
                        state_d = IDLE;
                        ld_d    = 1'b0;
                    end else begin
                        sec_d   = sec_q + SW'(1);
                        lba_d   = lba_q + LBA_W'(1);
                        rd_d    = ld_q;
                        wr_d    = ~ld_q;
                        state_d = REQ;
                    end
                end
            end
            FMT: begin
                if (fmt_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ena_d = ena_q;
        if (downloading && img_mounted && !img_readonly) ena_d = 1'b1;
        else if (edge_det(downloading, old_dl_q, 1'b1)) ena_d = 1'b0;
        pend_d = (core_we & ena_q & ~osd_open) | fmt_set
               | (pend_q & ~start_xfer);
    end

    always_comb begin
        ram_addr    = '0;
        ram_din     = '0;
        ram_we      = 1'b0;
        ram_sel_fmt = 1'b0;
        if (state_q == XFER) begin
            ram_addr = {sec_q, sd_buff_addr};
            ram_we   = sd_buff_wr & sd_ack & ld_q;
        end else if (state_q == FMT) begin
            ram_addr    = fmt_addr;
            ram_din     = fmt_data;
            ram_we      = fmt_run;
            ram_sel_fmt = 1'b1;
        end
    end

    assign sd_lba     = lba_q;
    assign sd_rd      = rd_q;
    assign sd_wr      = wr_q;
    assign bk_ena     = ena_q;
    assign bk_busy    = (state_q != IDLE);
    assign bk_loading = ld_q;
    assign bk_pending = pend_q;

endmodule

// File: tb/tb_bram_sd_ctrl.sv
// Scoreboard bench for bram_sd_ctrl: expected sector requests and
// RAM writes are queued by stimulus and popped by negedge monitors.
module tb_bram_sd_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, downloading, img_mounted, img_readonly, img_size_nz;
    logic load_req, save_req, format_req, autosave_en, osd_open, core_we;
    logic sd_ack, sd_buff_wr;
    logic [7:0] sd_buff_addr;
    logic [31:0] sd_lba;
    logic sd_rd, sd_wr, ram_we, ram_sel_fmt;
    logic [11:0] ram_addr;
    logic [15:0] ram_din;
    logic bk_ena, bk_busy, bk_loading, bk_pending;

    logic f_fmt_req;
    logic [31:0] f_lba;
    logic f_rd, f_wr, f_we, f_sel, f_ena, f_busy, f_loading, f_pending;
    logic [11:0] f_addr;
    logic [15:0] f_din;

    bram_sd_ctrl dut (
        .clk_sys(clk), .reset_n(reset_n), .downloading(downloading),
        .img_mounted(img_mounted), .img_readonly(img_readonly),
        .img_size_nz(img_size_nz), .load_req(load_req),
        .save_req(save_req), .format_req(format_req),
        .autosave_en(autosave_en), .osd_open(osd_open),
        .core_we(core_we), .sd_lba(sd_lba), .sd_rd(sd_rd),
        .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr),
        .sd_buff_wr(sd_buff_wr), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_we(ram_we), .ram_sel_fmt(ram_sel_fmt),
        .bk_ena(bk_ena), .bk_busy(bk_busy), .bk_loading(bk_loading),
        .bk_pending(bk_pending)
    );

    bram_sd_ctrl #(.FORMAT_CLEAR(1'b1)) dut_clr (
        .clk_sys(clk), .reset_n(reset_n), .downloading(1'b0),
        .img_mounted(1'b0), .img_readonly(1'b0),
        .img_size_nz(1'b0), .load_req(1'b0),
        .save_req(1'b0), .format_req(f_fmt_req),
        .autosave_en(1'b0), .osd_open(1'b0),
        .core_we(1'b0), .sd_lba(f_lba), .sd_rd(f_rd),
        .sd_wr(f_wr), .sd_ack(1'b0), .sd_buff_addr(8'h00),
        .sd_buff_wr(1'b0), .ram_addr(f_addr),
        .ram_din(f_din), .ram_we(f_we), .ram_sel_fmt(f_sel),
        .bk_ena(f_ena), .bk_busy(f_busy), .bk_loading(f_loading),
        .bk_pending(f_pending)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] lba;
    } req_t;

    typedef struct {
        logic [11:0] addr;
        logic        sel;
        logic [15:0] din;
    } wr_t;

    req_t req_q[$];
    wr_t  wr_q[$];
    wr_t  wr1_q[$];
    int checks = 0;
    int errors = 0;
    int load_we = 0;
    logic prev_req = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        req_t r;
        wr_t  w;
        if ((sd_rd | sd_wr) && !prev_req) begin
            if (req_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL req_unexpected: got rd=%b wr=%b lba=%h",
                         sd_rd, sd_wr, sd_lba);
            end else begin
                r = req_q.pop_front();
                chk("req_rd", 32'(sd_rd), 32'(r.rd));
                chk("req_wr", 32'(sd_wr), 32'(r.wr));
                chk("req_lba", sd_lba, r.lba);
            end
        end
        prev_req = sd_rd | sd_wr;
        if (ram_we === 1'b1) begin
            if (!ram_sel_fmt) load_we++;
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL we_unexpected: got addr=%h sel=%b",
                         ram_addr, ram_sel_fmt);
            end else begin
                w = wr_q.pop_front();
                chk("we_addr", 32'(ram_addr), 32'(w.addr));
                chk("we_sel", 32'(ram_sel_fmt), 32'(w.sel));
                if (w.sel) chk("we_din", 32'(ram_din), 32'(w.din));
            end
        end
    end

    always @(negedge clk) begin
        wr_t w;
        if (f_we === 1'b1) begin
            if (wr1_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL clr_unexpected: got addr=%h", f_addr);
            end else begin
                w = wr1_q.pop_front();
                chk("clr_addr", 32'(f_addr), 32'(w.addr));
                chk("clr_sel", 32'(f_sel), 32'(w.sel));
                chk("clr_din", 32'(f_din), 32'(w.din));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req;
        int n = 0;
        while (!(sd_rd | sd_wr) && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", 32'(sd_rd | sd_wr), 32'd1);
    endtask

    task automatic push_xfer(input logic ld, input int nsec);
        for (int s = 0; s < nsec; s++) begin
            req_q.push_back('{ld, ~ld, 32'(s)});
            if (ld) begin
                for (int i = 0; i < 256; i++)
                    wr_q.push_back('{12'(s * 256 + i), 1'b0, 16'h0});
            end
        end
    endtask

    task automatic do_sector(input logic ld);
        wait_req();
        tick();
        sd_ack = 1'b1;
        tick();
        chk("req_clr", 32'({sd_rd, sd_wr}), 32'd0);
        for (int i = 0; i < 256; i++) begin
            sd_buff_addr = 8'(i);
            sd_buff_wr   = ld;
            tick();
        end
        sd_buff_wr = 1'b0;
        sd_ack     = 1'b0;
        tick();
    endtask

    task automatic mount_and_load;
        downloading = 1'b1;
        tick();
        img_mounted = 1'b1;
        tick();
        img_mounted = 1'b0;
        chk("ena_set", 32'(bk_ena), 32'd1);
        push_xfer(1'b1, 16);
        img_size_nz = 1'b1;
        downloading = 1'b0;
        tick();
        chk("load_rd_lat", 32'(sd_rd), 32'd1);
        chk("load_flags", 32'({bk_busy, bk_loading}), 32'd3);
        for (int s = 0; s < 16; s++) do_sector(1'b1);
        chk("load_done", 32'({bk_busy, bk_loading}), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        {downloading, img_mounted, img_readonly, img_size_nz} = '0;
        {load_req, save_req, format_req, autosave_en} = '0;
        {osd_open, core_we, sd_ack, sd_buff_wr, f_fmt_req} = '0;
        sd_buff_addr = '0;
        repeat (3) tick();
        chk("rst_flags", 32'({sd_rd, sd_wr, ram_we, ram_sel_fmt,
                              bk_ena, bk_busy, bk_loading, bk_pending}), 32'd0);
        chk("rst_lba", sd_lba, 32'd0);
        chk("rst_ram", 32'({ram_addr, ram_din}), 32'd0);
        reset_n = 1'b1;
        tick();

        mount_and_load();
        chk("load_we_cnt", 32'(load_we), 32'd4096);
        chk("load_wrq", 32'(wr_q.size()), 32'd0);

        core_we = 1'b1;
        tick();
        core_we = 1'b0;
        chk("pend_set", 32'(bk_pending), 32'd1);
        push_xfer(1'b0, 16);
        save_req = 1'b1;
        tick();
        chk("save_start", 32'({sd_rd, sd_wr, bk_pending}), 32'b010);
        for (int s = 0; s < 16; s++) do_sector(1'b0);
        save_req = 1'b0;
        tick();
        chk("save_done", 32'({bk_busy, bk_loading}), 32'd0);

        autosave_en = 1'b1;
        core_we = 1'b1;
        tick();
        core_we = 1'b0;
        push_xfer(1'b0, 16);
        osd_open = 1'b1;
        tick();
        chk("auto_start", 32'({sd_wr, bk_pending}), 32'b10);
        for (int s = 0; s < 16; s++) do_sector(1'b0);
        repeat (3) tick();
        osd_open = 1'b0;
        tick();
        osd_open = 1'b1;
        repeat (5) tick();
        chk("auto_once", 32'({bk_busy, sd_wr}), 32'd0);
        chk("auto_reqq", 32'(req_q.size()), 32'd0);
        osd_open = 1'b0;
        autosave_en = 1'b0;
        tick();

        push_xfer(1'b1, 16);
        load_req = 1'b1;
        save_req = 1'b1;
        tick();
        chk("prio_load", 32'({sd_rd, sd_wr}), 32'b10);
        do_sector(1'b1);
        save_req = 1'b0;
        tick();
        save_req = 1'b1;
        for (int s = 1; s < 16; s++) do_sector(1'b1);
        repeat (5) tick();
        chk("prio_drop", 32'({bk_busy, sd_rd, sd_wr}), 32'd0);
        load_req = 1'b0;
        save_req = 1'b0;
        tick();

        wr_q.push_back('{12'h000, 1'b1, 16'h5548});
        wr_q.push_back('{12'h001, 1'b1, 16'h4D42});
        wr_q.push_back('{12'h002, 1'b1, 16'h8800});
        wr_q.push_back('{12'h003, 1'b1, 16'h8010});
        format_req = 1'b1;
        tick();
        format_req = 1'b0;
        repeat (6) tick();
        chk("fmt_wrq", 32'(wr_q.size()), 32'd0);
        chk("fmt_end", 32'({bk_busy, bk_pending}), 32'b01);

        wr1_q.push_back('{12'h000, 1'b1, 16'h5548});
        wr1_q.push_back('{12'h001, 1'b1, 16'h4D42});
        wr1_q.push_back('{12'h002, 1'b1, 16'h8800});
        wr1_q.push_back('{12'h003, 1'b1, 16'h8010});
        for (int a = 4; a < 4096; a++)
            wr1_q.push_back('{12'(a), 1'b1, 16'h0000});
        f_fmt_req = 1'b1;
        tick();
        f_fmt_req = 1'b0;
        repeat (4100) tick();
        chk("clr_wrq", 32'(wr1_q.size()), 32'd0);
        chk("clr_busy", 32'(f_busy), 32'd0);

        push_xfer(1'b1, 5);
        req_q.push_back('{1'b1, 1'b0, 32'd5});
        for (int i = 0; i < 100; i++)
            wr_q.push_back('{12'(5 * 256 + i), 1'b0, 16'h0});
        load_req = 1'b1;
        tick();
        for (int s = 0; s < 5; s++) do_sector(1'b1);
        wait_req();
        tick();
        sd_ack = 1'b1;
        tick();
        for (int i = 0; i < 100; i++) begin
            sd_buff_addr = 8'(i);
            sd_buff_wr   = 1'b1;
            tick();
        end
        reset_n = 1'b0;
        #1;
        chk("arst_flags", 32'({sd_rd, sd_wr, ram_we, ram_sel_fmt,
                               bk_ena, bk_busy, bk_loading, bk_pending}), 32'd0);
        chk("arst_lba", sd_lba, 32'd0);
        sd_ack = 1'b0;
        sd_buff_wr = 1'b0;
        load_req = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst", 32'({bk_ena, bk_busy}), 32'd0);
        chk("rst_queues", 32'(wr_q.size() + req_q.size()), 32'd0);
        mount_and_load();
        chk("end_queues", 32'(wr_q.size() + req_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
